// File: rtl/uart_inst_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_inst_loader_pkg                                             |
// | Shared sequencer widths, loader state encoding and gap default.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_inst_loader_pkg;

  localparam int seq_in_width        = 8;
  localparam int LDR_GAP_CYC_DEFAULT = 4;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_GAP  = 2'd1,
    LDR_WAIT = 2'd2
  } ldr_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_inst_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_inst_loader_if                                              |
// | UART-rx / sequencer-side signal bundle of the instruction loader.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface uart_inst_loader_if
  import uart_inst_loader_pkg::*;
#(
  parameter int IN_W  = seq_in_width,
  parameter int DEPTH = 8
);
  logic [7:0]             i_rx_data;
  logic                   i_rx_valid;
  logic                   i_tx_busy;
  logic                   i_hold;
  logic [IN_W-1:0]        o_inst;
  logic                   o_inst_valid;
  logic [$clog2(DEPTH):0] o_fifo_count;
  logic                   o_overflow;

  modport master (
    output i_rx_data, i_rx_valid, i_tx_busy, i_hold,
    input  o_inst, o_inst_valid, o_fifo_count, o_overflow
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_busy, i_hold,
    output o_inst, o_inst_valid, o_fifo_count, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_inst_loader_rx_inst_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rx_inst_fifo                                                     |
// | Synchronous FIFO with occupancy count, push-on-pop when full and |
// | a drop strobe for rejected writes.                               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rx_inst_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push_i,
  input  wire logic [W-1:0]           data_i,
  input  wire logic                   pop_i,
  output logic      [W-1:0]           data_o,
  output logic      [$clog2(DEPTH):0] count_o,
  output logic                        drop_o
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [W-1:0]      mem_q [DEPTH];
  logic [c_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_CW-1:0]   count_q, count_d;
  logic              w_full, w_pop, w_push;

  assign w_full = (count_q == c_CW'(DEPTH));
  assign w_pop  = pop_i && (count_q != '0);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push = push_i && (!w_full || w_pop);

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign drop_o  = push_i && !w_push;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_CW'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
      count_q <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_inst_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_inst_loader                                                 |
// | Buffers UART rx bytes and issues them as paced instruction pulses|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_inst_loader
  import uart_inst_loader_pkg::*;
#(
  parameter int IN_W    = seq_in_width,
  parameter int DEPTH   = 8,
  parameter int GAP_CYC = LDR_GAP_CYC_DEFAULT
) (
  input wire logic         clk,
  input wire logic         rst,
  uart_inst_loader_if.slave bus
);
  localparam int c_GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_INIT = c_GAP_W'(GAP_CYC - 1);

  ldr_state_e             state_q, state_d;
  logic [c_GAP_W-1:0]     gap_q, gap_d;
  logic [IN_W-1:0]        inst_q, inst_d;
  logic                   inst_valid_q, inst_valid_d;
  logic                   overflow_q;
  logic                   w_pop, w_drop;
  logic [IN_W-1:0]        w_head;
  logic [$clog2(DEPTH):0] w_count;

  rx_inst_fifo #(
    .W     (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.i_rx_valid),
    .data_i  (bus.i_rx_data[IN_W-1:0]),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count),
    .drop_o  (w_drop)
  );

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    w_pop        = 1'b0;
    unique case (state_q)
      LDR_IDLE: begin
        if ((w_count != '0) && !bus.i_hold && !bus.i_tx_busy) begin
          w_pop        = 1'b1;
          inst_d       = w_head;
          inst_valid_d = 1'b1;
          gap_d        = c_GAP_INIT;
          state_d      = LDR_GAP;
        end
      end
      LDR_GAP: begin
        if (gap_q == '0) begin
          state_d = LDR_WAIT;
        end else begin
          gap_d = gap_q - c_GAP_W'(1);
        end
      end
      LDR_WAIT: begin
        // Gives the sequencer's transmit time to start before we look at busy.
        if (!bus.i_tx_busy) state_d = LDR_IDLE;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LDR_IDLE;
      gap_q        <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      if (w_drop) overflow_q <= 1'b1;
    end
  end

  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = inst_valid_q;
  assign bus.o_fifo_count = w_count;
  assign bus.o_overflow   = overflow_q;
endmodule
`default_nettype wire
